prog_loader: RTL and testbench

- Byte-stream program loader sitting directly upstream of the instruction memory in the BatPU2 toplevel.
- Consumes bytes from a UART RX (valid/ready) and assembles 16-bit instruction words.
- Writes those words sequentially into instruction RAM starting at address 0.
- Holds the CPU in reset while loading and releases it on successful completion.

---
 rtl/bpu_loader_pkg.sv | 20 ++
 rtl/prog_loader.sv | 162 ++++++++++++++++
 tb/tb_prog_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_loader_pkg.sv
// Shared types and frame constants for the BatPU2 program loader.
package bpu_loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SYNC,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA_LO,
      ST_DATA_HI,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } loader_state_t;

   localparam logic [7:0] LOADER_MAGIC   = 8'hB2;
   localparam int         LEN_BYTES      = 2;
   localparam int         BYTES_PER_WORD = 2;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: MAGIC, 16-bit LE word count, then lo/hi byte pairs into imem.
// Optional trailing checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
//
// state      | meaning
// IDLE       | after reset, CPU runs from existing imem contents
// SYNC       | hunting for the MAGIC byte, other bytes dropped
// LEN_LO     | waiting for word count low byte
// LEN_HI     | waiting for word count high byte, count validated on accept
// DATA_LO    | waiting for instruction low byte
// DATA_HI    | waiting for instruction high byte, write issued on accept
// CHECK      | waiting for checksum byte (checksum build only)
// DONE       | load complete, CPU released
// ERROR      | bad length or checksum, CPU held in reset
module prog_loader
   import bpu_loader_pkg::*;
#(
   parameter int         ADDR_W = 10,
   parameter logic [7:0] MAGIC  = LOADER_MAGIC
) (
   input  logic              clk,
   input  logic              clk_en,
   input  logic              sync_rst,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   loader_state_t state, state_nxt;

   logic                           accept;
   logic                           frame_start;
   logic                           len_bad;
   logic                           last_word;
   logic [LEN_BYTES*8-1:0]         len_rx;
   logic [7:0]                     len_lo;
   logic [7:0]                     lo_byte;
   logic [ADDR_W:0]                len_q;
   logic [ADDR_W-1:0]              addr;
   logic                           we_q;
   logic [8*BYTES_PER_WORD-1:0]    wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]                     sum;
`endif

   assign rx_ready  = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);
   assign accept    = rx_valid & rx_ready & clk_en;
   assign len_rx    = {rx_data, len_lo};
   assign len_bad   = (len_rx == '0) || (32'(len_rx) > (32'd1 << ADDR_W));
   assign last_word = (words_loaded + (ADDR_W+1)'(1)) == len_q;

   // Strobe is qualified so the RAM sees exactly one enabled write cycle.
   assign imem_we    = we_q & clk_en;
   assign imem_wdata = wdata_q;

   always_ff @(posedge clk) begin
      if (sync_rst)
         state <= ST_IDLE;
      else if (clk_en)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_nxt   = ST_SYNC;
               frame_start = 1'b1;
            end
         end
         ST_SYNC:    if (accept && rx_data == MAGIC) state_nxt = ST_LEN_LO;
         ST_LEN_LO:  if (accept) state_nxt = ST_LEN_HI;
         ST_LEN_HI:  if (accept) state_nxt = len_bad ? ST_ERROR : ST_DATA_LO;
         ST_DATA_LO: if (accept) state_nxt = ST_DATA_HI;
         ST_DATA_HI: begin
            if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
               state_nxt = last_word ? ST_CHECK : ST_DATA_LO;
`else
               state_nxt = last_word ? ST_DONE : ST_DATA_LO;
`endif
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         ST_CHECK:   if (accept) state_nxt = (rx_data == sum) ? ST_DONE : ST_ERROR;
`endif
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         cpu_hold     <= 1'b0;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= '0;
         addr         <= '0;
         len_lo       <= '0;
         len_q        <= '0;
         lo_byte      <= '0;
         we_q         <= 1'b0;
         imem_addr    <= '0;
         wdata_q      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum          <= '0;
`endif
      end else if (clk_en) begin
         we_q <= 1'b0;
         if (frame_start) begin
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            addr         <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
         end else begin
            // Release lags entry to DONE by one cycle so it trails the last write strobe.
            if (state == ST_DONE) begin
               cpu_hold  <= 1'b0;
               load_done <= 1'b1;
            end
            if (state_nxt == ST_ERROR)
               load_err <= 1'b1;
            if (accept) begin
               case (state)
                  ST_LEN_LO: len_lo <= rx_data;
                  ST_LEN_HI: len_q  <= len_rx[ADDR_W:0];
                  ST_DATA_LO: begin
                     lo_byte <= rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                     sum     <= sum + rx_data;
`endif
                  end
                  ST_DATA_HI: begin
                     we_q         <= 1'b1;
                     imem_addr    <= addr;
                     wdata_q      <= {rx_data, lo_byte};
                     addr         <= addr + 1'b1;
                     words_loaded <= words_loaded + (ADDR_W+1)'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                     sum          <= sum + rx_data;
`endif
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected writes, a monitor checks imem strobes.
module tb_prog_loader;
   import bpu_loader_pkg::*;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              clk_en;
   logic              sync_rst;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   int         pass_cnt  = 0;
   int         total_cnt = 0;
   int         wr_cnt    = 0;
   bit         rand_mode = 1'b0;
   int         exp_a[$];
   int         exp_d[$];
   logic [7:0] dat[$];

   prog_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .clk_en       (clk_en),
      .sync_rst     (sync_rst),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (imem_we) begin
         wr_cnt++;
         if (exp_a.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                     imem_addr, imem_wdata);
         end else begin
            chk("wr_addr", int'(imem_addr), exp_a.pop_front());
            chk("wr_data", int'(imem_wdata), exp_d.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int  n = 0;
      bit  done = 1'b0;
      int  wl;
      rx_data = b;
      while (!done) begin
         rx_valid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         clk_en   = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         wl = int'(words_loaded);
         if (rx_valid && clk_en && rx_ready) done = 1'b1;
         @(posedge clk);
         #1;
         if (!clk_en) chk("gated_hold", int'(words_loaded), wl);
         n++;
         if (!done && n > 200) begin
            total_cnt++;
            $display("FAIL byte_timeout: got no accept expected accept of %0h", b);
            done = 1'b1;
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] len, input bit ok,
                             input bit chk_ovr, input logic [7:0] chk_val);
      logic [7:0] s = 8'h00;
      if (ok) begin
         for (int i = 0; i < dat.size() / 2; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(int'({dat[2*i+1], dat[2*i]}));
            s = s + dat[2*i] + dat[2*i+1];
         end
      end
      send_byte(LOADER_MAGIC);
      send_byte(len[7:0]);
      send_byte(len[15:8]);
      if (ok) begin
         for (int i = 0; i < dat.size(); i++) send_byte(dat[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
         send_byte(chk_ovr ? chk_val : s);
`endif
      end
      clk_en = 1'b1;
   endtask

   task automatic settle(input int n);
      clk_en = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      clk_en = 1'b1;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   task automatic frame1();
      dat.delete();
      dat.push_back(8'h11); dat.push_back(8'h22); dat.push_back(8'h33);
      dat.push_back(8'h44); dat.push_back(8'h55); dat.push_back(8'h66);
   endtask

   task automatic check_done(input string tag, input int words);
      settle(3);
      chk({tag, "_done"}, int'(load_done), 1);
      chk({tag, "_err"}, int'(load_err), 0);
      chk({tag, "_hold"}, int'(cpu_hold), 0);
      chk({tag, "_words"}, int'(words_loaded), words);
      chk({tag, "_qempty"}, exp_a.size(), 0);
   endtask

   task automatic check_err(input string tag, input int wr_before, input int wr_exp);
      settle(3);
      chk({tag, "_err"}, int'(load_err), 1);
      chk({tag, "_done"}, int'(load_done), 0);
      chk({tag, "_hold"}, int'(cpu_hold), 1);
      chk({tag, "_ready"}, int'(rx_ready), 0);
      chk({tag, "_writes"}, wr_cnt - wr_before, wr_exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0;
      clk_en = 1'b1; sync_rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      sync_rst = 1'b0;
      chk("rst_hold", int'(cpu_hold), 0);
      chk("rst_done", int'(load_done), 0);
      chk("rst_err", int'(load_err), 0);
      chk("rst_ready", int'(rx_ready), 0);
      chk("rst_words", int'(words_loaded), 0);

      // Basic three-word frame, back-to-back bytes.
      do_start();
      chk("start_hold", int'(cpu_hold), 1);
      chk("start_ready", int'(rx_ready), 1);
      frame1();
      send_frame(16'd3, 1'b1, 1'b0, 8'h00);
      check_done("f1", 3);

      // Garbage before sync byte.
      do_start();
      send_byte(8'h00);
      send_byte(8'hFF);
      dat.delete();
      dat.push_back(8'h34); dat.push_back(8'h12);
      send_frame(16'd1, 1'b1, 1'b0, 8'h00);
      check_done("garb", 1);

      // Zero length.
      do_start();
      wr0 = wr_cnt;
      send_frame(16'h0000, 1'b0, 1'b0, 8'h00);
      check_err("len0", wr0, 0);
      chk("len0_words", int'(words_loaded), 0);

      // One past capacity.
      do_start();
      wr0 = wr_cnt;
      send_frame(16'h0401, 1'b0, 1'b0, 8'h00);
      check_err("len1025", wr0, 0);

      // Exactly full capacity: last write lands at 1023.
      do_start();
      dat.delete();
      for (int i = 0; i < 1024; i++) begin
         dat.push_back(8'(i));
         dat.push_back(8'(i >> 8) ^ 8'h5A);
      end
      send_frame(16'h0400, 1'b1, 1'b0, 8'h00);
      check_done("full", 1024);

`ifdef PROG_LOADER_CHECKSUM_EN
      do_start();
      wr0 = wr_cnt;
      dat.delete();
      dat.push_back(8'h01); dat.push_back(8'h02);
      send_frame(16'd1, 1'b1, 1'b1, 8'h04);
      check_err("cks_bad", wr0, 1);
      do_start();
      send_frame(16'd1, 1'b1, 1'b1, 8'h03);
      check_done("cks_ok", 1);
`endif

      // Random rx_valid and clk_en gating.
      do_start();
      frame1();
      rand_mode = 1'b1;
      send_frame(16'd3, 1'b1, 1'b0, 8'h00);
      rand_mode = 1'b0;
      check_done("rand", 3);

      // Reset after two data words.
      do_start();
      exp_a.push_back(0); exp_d.push_back(32'h0201);
      exp_a.push_back(1); exp_d.push_back(32'h0403);
      send_byte(LOADER_MAGIC);
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02);
      send_byte(8'h03); send_byte(8'h04);
      @(negedge clk);
      @(posedge clk);
      #1;
      sync_rst = 1'b1;
      @(posedge clk);
      #1;
      sync_rst = 1'b0;
      chk("mid_hold", int'(cpu_hold), 0);
      chk("mid_done", int'(load_done), 0);
      chk("mid_err", int'(load_err), 0);
      chk("mid_ready", int'(rx_ready), 0);
      chk("mid_words", int'(words_loaded), 0);
      chk("mid_qempty", exp_a.size(), 0);
      do_start();
      frame1();
      send_frame(16'd3, 1'b1, 1'b0, 8'h00);
      check_done("post_rst", 3);

      settle(2);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
